// File: rtl/dmem_wbuf.sv
// -----------------------------------------------------------------------------
// dmem_wbuf : data memory fronted by an in-order store write buffer.
//
// Stores are queued as {word index, byte sel, data}. The buffer drains one
// entry per cycle into the array while the load port is idle. When the buffer
// is full, the drain is forced and stores are held off. Loads see the array
// word with buffered bytes overlaid, oldest to newest, so the newest buffered
// byte for each lane wins.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_wr_req_i     store request
//   mem_wr_addr_i    store byte address (word index = addr[ADDR_W+1:2])
//   mem_wr_sel_i     byte-lane enables
//   mem_wr_data_i    lane-aligned store data
//   mem_rd_req_i     load request; owns the array port this cycle
//   mem_rd_addr_i    load byte address
//   mem_rd_data_o    forwarded load word (combinational, always valid)
//   hold_flag_o      stall request, high while the buffer is full
//   wb_count_o       number of buffered entries
//   wb_empty_o       buffer empty
// -----------------------------------------------------------------------------
module dmem_wbuf #(
   parameter int ADDR_W   = 12,
   parameter int WB_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        mem_wr_req_i,
   input  logic [31:0]                 mem_wr_addr_i,
   input  logic [3:0]                  mem_wr_sel_i,
   input  logic [31:0]                 mem_wr_data_i,
   input  logic                        mem_rd_req_i,
   input  logic [31:0]                 mem_rd_addr_i,
   output logic [31:0]                 mem_rd_data_o,
   output logic                        hold_flag_o,
   output logic [$clog2(WB_DEPTH):0]   wb_count_o,
   output logic                        wb_empty_o
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [3:0]        sel;
      logic [31:0]       data;
   } wb_entry_t;

   logic [31:0]         mem_q [2**ADDR_W];
   wb_entry_t           ent_q [WB_DEPTH];
   logic [WB_DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                full_q, full_d;
   logic                enq, drain;
   logic [ADDR_W-1:0]   wr_idx, rd_idx;
   logic [PTR_W-1:0]    slot;
   logic [31:0]         rd_data;
   logic                unused_addr_bits;

   assign wr_idx = mem_wr_addr_i[ADDR_W+1:2];
   assign rd_idx = mem_rd_addr_i[ADDR_W+1:2];

   // Byte offset and bits above the array size are ignored (address wraps).
   assign unused_addr_bits = ^{mem_wr_addr_i[31:ADDR_W+2], mem_wr_addr_i[1:0],
                               mem_rd_addr_i[31:ADDR_W+2], mem_rd_addr_i[1:0]};

   // A full buffer refuses the store and drains unconditionally, so a full
   // buffer never enqueues and dequeues in the same cycle.
   always_comb begin
      enq     = mem_wr_req_i && (mem_wr_sel_i != 4'b0000) && !full_q;
      drain   = (count_q != '0) && (full_q || !mem_rd_req_i);
      count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
      full_d  = (count_d == CNT_W'(WB_DEPTH));
      vld_d   = vld_q;
      if (drain) vld_d[rd_ptr_q] = 1'b0;
      if (enq)   vld_d[wr_ptr_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         vld_q    <= '0;
      end else begin
         if (enq)   wr_ptr_q <= wr_ptr_q + 1'b1;
         if (drain) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= full_d;
         vld_q   <= vld_d;
      end
   end

   // Entry payload needs no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (enq) ent_q[wr_ptr_q] <= '{idx: wr_idx, sel: mem_wr_sel_i, data: mem_wr_data_i};
   end

   // Array is never reset. rst_n gating keeps a drain coinciding with reset
   // assertion from landing in the array.
   always_ff @(posedge clk) begin
      if (drain && rst_n) begin
         for (int b = 0; b < 4; b++) begin
            if (ent_q[rd_ptr_q].sel[b])
               mem_q[ent_q[rd_ptr_q].idx][8*b +: 8] <= ent_q[rd_ptr_q].data[8*b +: 8];
         end
      end
   end

   // Walk entries from the head (oldest) forward so later matches overwrite
   // earlier ones lane by lane.
   always_comb begin
      rd_data = mem_q[rd_idx];
      slot    = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         slot = rd_ptr_q + PTR_W'(i);
         if (vld_q[slot] && (ent_q[slot].idx == rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
               if (ent_q[slot].sel[b]) rd_data[8*b +: 8] = ent_q[slot].data[8*b +: 8];
            end
         end
      end
   end

   assign mem_rd_data_o = rd_data;
   assign hold_flag_o   = full_q;
   assign wb_count_o    = count_q;
   assign wb_empty_o    = (count_q == '0);

endmodule

// File: tb/tb_dmem_wbuf.sv
module tb_dmem_wbuf;

   localparam int ADDR_W   = 12;
   localparam int WB_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_req = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [3:0]  wr_sel = '0;
   logic [31:0] wr_data = '0;
   logic        rd_req = 1'b0;
   logic [31:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic        hold;
   logic [$clog2(WB_DEPTH):0] wb_count;
   logic        wb_empty;

   always #5 clk = ~clk;

   dmem_wbuf #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_wr_req_i(wr_req), .mem_wr_addr_i(wr_addr), .mem_wr_sel_i(wr_sel),
      .mem_wr_data_i(wr_data), .mem_rd_req_i(rd_req), .mem_rd_addr_i(rd_addr),
      .mem_rd_data_o(rd_data), .hold_flag_o(hold), .wb_count_o(wb_count),
      .wb_empty_o(wb_empty)
   );

   // ---------------- reference model: word map + FIFO of pending stores ----
   typedef struct {
      int          idx;
      logic [3:0]  sel;
      logic [31:0] data;
   } ment_t;

   typedef struct {
      logic [31:0] rd;
      bit          rd_known;
      int          cnt;
      bit          hold;
      bit          empty;
   } exp_t;

   logic [31:0] mmem [int];
   ment_t       mq [$];
   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          pool [8] = '{0, 1, 2, 7, 'h10, 'h40, 'h41, 'hFFF};

   function automatic int widx(input logic [31:0] a);
      return int'(a[ADDR_W+1:2]);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] w;
      int          ix;
      ix = widx(a);
      w  = mmem.exists(ix) ? mmem[ix] : 32'h0;
      foreach (mq[k]) begin
         if (mq[k].idx == ix) begin
            for (int b = 0; b < 4; b++)
               if (mq[k].sel[b]) w[8*b +: 8] = mq[k].data[8*b +: 8];
         end
      end
      return w;
   endfunction

   function automatic exp_t model_expect(input logic [31:0] a);
      exp_t e;
      e.rd       = model_read(a);
      e.rd_known = mmem.exists(widx(a));
      e.cnt      = mq.size();
      e.hold     = (mq.size() == WB_DEPTH);
      e.empty    = (mq.size() == 0);
      return e;
   endfunction

   // Clock-edge rule: a full buffer refuses the store and always drains;
   // otherwise drain only on an idle load port; sel==0 is discarded.
   task automatic model_edge(input bit wr, input logic [31:0] wa, input logic [3:0] ws,
                             input logic [31:0] wd, input bit rd);
      bit    full;
      ment_t h;
      ment_t n;
      full = (mq.size() == WB_DEPTH);
      if (mq.size() > 0 && (full || !rd)) begin
         h = mq.pop_front();
         if (!mmem.exists(h.idx)) mmem[h.idx] = 32'h0;
         for (int b = 0; b < 4; b++)
            if (h.sel[b]) mmem[h.idx][8*b +: 8] = h.data[8*b +: 8];
      end
      if (wr && ws != 4'b0000 && !full) begin
         n.idx = widx(wa); n.sel = ws; n.data = wd;
         mq.push_back(n);
      end
   endtask

   // ---------------- stimulus ---------------------------------------------
   task automatic step(input bit wr, input logic [31:0] wa, input logic [3:0] ws,
                       input logic [31:0] wd, input bit rd, input logic [31:0] ra);
      @(negedge clk);
      wr_req = wr; wr_addr = wa; wr_sel = ws; wr_data = wd;
      rd_req = rd; rd_addr = ra;
      #1;
      exp_q.push_back(model_expect(ra));
      @(posedge clk);
      if (rst_n) model_edge(wr, wa, ws, wd, rd);
   endtask

   task automatic idle(input bit rd, input logic [31:0] ra);
      step(1'b0, 32'h0, 4'h0, 32'h0, rd, ra);
   endtask

   // Reset lands between edges; outputs are checked before the next edge.
   task automatic do_reset(input logic [31:0] ra);
      @(negedge clk);
      wr_req = 1'b0; wr_sel = '0; rd_req = 1'b1; rd_addr = ra;
      #1;
      rst_n = 1'b0;
      mq.delete();
      exp_q.push_back(model_expect(ra));
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] raddr();
      logic [31:0] r;
      logic [11:0] ix;
      r  = $urandom();
      ix = 12'(pool[$urandom_range(0, 7)]);
      return {r[31:14], ix, r[1:0]};
   endfunction

   // ---------------- monitor / scoreboard ---------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.rd_known) chk("rd_data", rd_data, e.rd);
            chk("wb_count", 32'(wb_count), 32'(e.cnt));
            chk("hold_flag", 32'(hold), 32'(e.hold));
            chk("wb_empty", 32'(wb_empty), 32'(e.empty));
         end
      end
   end

   initial begin
      do_reset(32'h0);

      // give every pool word a known value
      foreach (pool[p]) step(1'b1, 32'(pool[p]) << 2, 4'hF, $urandom(), 1'b0, 32'h0);
      repeat (3) idle(1'b0, 32'h0);

      // full-word store, held off by loads, forwarded, then drained
      step(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, 32'h100);
      repeat (3) idle(1'b1, 32'h100);
      idle(1'b0, 32'h100);
      idle(1'b0, 32'h100);

      // lane merge over an existing array word
      step(1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, 32'h40);
      idle(1'b0, 32'h40);
      step(1'b1, 32'h40, 4'b0100, 32'h00AA0000, 1'b1, 32'h40);
      step(1'b1, 32'h40, 4'b0001, 32'h000000BB, 1'b1, 32'h40);
      idle(1'b1, 32'h40);
      repeat (3) idle(1'b0, 32'h40);

      // fill, refuse, forced drain, re-present
      step(1'b1, 32'h0,  4'hF, 32'h01010101, 1'b1, 32'h0);
      step(1'b1, 32'h4,  4'hF, 32'h02020202, 1'b1, 32'h4);
      step(1'b1, 32'h8,  4'hF, 32'h03030303, 1'b1, 32'h8);
      step(1'b1, 32'h1C, 4'hF, 32'h04040404, 1'b1, 32'h0);
      step(1'b1, 32'h3FFC, 4'hF, 32'h05050505, 1'b1, 32'h3FFC);
      step(1'b1, 32'h3FFC, 4'hF, 32'h05050505, 1'b1, 32'h3FFC);
      idle(1'b1, 32'h3FFC);
      repeat (5) idle(1'b0, 32'h3FFC);

      // aliasing addresses: later store wins
      step(1'b1, 32'h0000_4000, 4'hF, 32'hA5A5A5A5, 1'b1, 32'h0);
      step(1'b1, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h0);
      idle(1'b1, 32'h0);
      repeat (3) idle(1'b0, 32'h0);

      // reset with three stores buffered
      step(1'b1, 32'h4, 4'hF, 32'hCAFE0001, 1'b1, 32'h4);
      step(1'b1, 32'h8, 4'hF, 32'hCAFE0002, 1'b1, 32'h8);
      step(1'b1, 32'h1C, 4'hF, 32'hCAFE0003, 1'b1, 32'h4);
      do_reset(32'h8);
      idle(1'b1, 32'h4);
      idle(1'b1, 32'h8);
      idle(1'b1, 32'h1C);

      // sel=0 store is discarded
      step(1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h8);
      idle(1'b0, 32'h8);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 249) == 0) do_reset(raddr());
         else step($urandom_range(0, 99) < 60, raddr(), 4'($urandom_range(0, 15)),
                   $urandom(), $urandom_range(0, 99) < 55, raddr());
      end
      repeat (6) idle(1'b0, raddr());

      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_W, 12, word-index width; array holds 2^ADDR_W 32-bit words.
- WB_DEPTH, 4, write-buffer entries; power of two, at least 2.
REQ-002 Clock and reset SHALL be one clock and an asynchronous active-low reset:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- mem_wr_req_i  in  1  store request from execute stage.
- mem_wr_addr_i  in  32  store byte address.
- mem_wr_sel_i  in  4  byte-lane enables; bit n selects data[8n+7:8n].
- mem_wr_data_i  in  32  lane-aligned store data.
- mem_rd_req_i  in  1  load request; claims the array port this cycle.
- mem_rd_addr_i  in  32  load byte address.
- mem_rd_data_o  out  32  full load word, combinational.
- hold_flag_o  out  1  stall request to pipeline control.
- wb_count_o  out  log2(WB_DEPTH)+1  buffered-entry count.
- wb_empty_o  out  1  buffer empty.

Function
REQ-004 Word index SHALL be addr[ADDR_W+1:2] for both ports; addr[1:0] and bits above ADDR_W+1 SHALL be ignored, so addresses wrap modulo the array size.
REQ-005 The buffer SHALL be an in-order FIFO; each entry holds {word index, sel, data}.
REQ-006 Enqueue SHALL occur at the rising edge when mem_wr_req_i=1, mem_wr_sel_i!=0 and hold_flag_o=0.
REQ-007 A request with mem_wr_sel_i=0 SHALL be discarded without enqueue.
REQ-008 Drain SHALL write the head entry into the array, updating only lanes with sel=1, and pop it, at most one entry per cycle.
REQ-009 Drain arbitration:
- Buffer non-empty and not full: drain occurs only when mem_rd_req_i=0.
- Buffer full: drain is forced regardless of mem_rd_req_i.
REQ-010 hold_flag_o SHALL equal (count==WB_DEPTH), driven from a registered full flag.
REQ-011 Full buffer with an incoming store: the store SHALL NOT be enqueued and the forced drain SHALL occur, so count goes WB_DEPTH to WB_DEPTH-1 and hold deasserts the next cycle; the producer re-presents the store.
REQ-012 Simultaneous enqueue and drain when not full SHALL leave count unchanged; pointers SHALL wrap modulo WB_DEPTH.
REQ-013 mem_rd_data_o SHALL be computed per byte lane:
- Start from the array word at the read index.
- Overlay, oldest to newest, each valid entry with matching index and that lane's sel=1.
- The newest matching lane wins.
REQ-014 Forwarding SHALL NOT include the store presented in the same cycle; an accepted store is visible to loads from the next cycle onward.
REQ-015 mem_rd_data_o SHALL be valid in every cycle regardless of mem_rd_req_i, including the forced-drain cycle.
REQ-016 wb_count_o and wb_empty_o SHALL reflect registered state only.

Reset
REQ-017 On rst_n=0, immediately and independent of clk:
- Pointers and count SHALL reset to 0.
- Full flag and hold_flag_o SHALL reset to 0.
- wb_empty_o SHALL reset to 1.
- Buffered entries SHALL be invalidated and discarded.
REQ-018 Array contents SHALL NOT be reset.
REQ-019 A store pending or a drain in progress when reset asserts SHALL be lost with no partial array write.
REQ-020 After rst_n deasserts, the first enqueue SHALL be possible at the first rising edge.

Verification
REQ-021 Full-word store: write 0x100 <- 0xDEADBEEF with sel=1111, mem_rd_req_i held 1 for 3 cycles -> entry not drained (count=1); read of 0x100 returns 0xDEADBEEF via forwarding; drop rd_req -> drain next edge, count=0, read still 0xDEADBEEF.
REQ-022 Lane merge: array[0x40]=0x11223344; store sel=0100 data=0x00AA0000, then sel=0001 data=0x000000BB, rd_req held 1 -> read of 0x40 returns 0x11AA33BB before and after drain.
REQ-023 Full/hold: rd_req held 1, four stores to distinct words -> count=4, hold_flag_o=1; fifth store refused; forced drain gives count=3, hold=0; re-presented fifth store accepted at the next edge.
REQ-024 Wrap-around and ordering: with ADDR_W=12, store 0x0000_4000 <- 0xA5A5A5A5, then store 0x0 <- 0x5A5A5A5A -> both map to index 0; after drain, array[0]=0x5A5A5A5A.
REQ-025 Reset mid-operation: three stores buffered, assert rst_n low between edges -> count=0, empty=1, hold=0 immediately; after release, reads of those addresses return prior array contents.
REQ-026 sel=0 store: wr_req=1, sel=0000 -> count unchanged, array unchanged.
